// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - ALU control codes and shared constants for the EX-stage execute unit
package alu_exec_pkg;

    localparam int ALU_CTRL_W = 3;
    localparam int SHAMT_W    = 5;

    // ALU control code as produced by the ALU control decoder
    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_SRAI = 3'b110,
        ALU_RSVD = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, MUL_BITS_PER_CY multiplier bits per cycle
module alu_mul_iter #(
    parameter int DATA_W          = 32,
    parameter int MUL_BITS_PER_CY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] mcand_i,
    input  logic [DATA_W-1:0] mplier_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int N     = DATA_W / MUL_BITS_PER_CY;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } mul_state_e;

    mul_state_e        state_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] acc_next;
    logic              last_step;

    // One partial product per cycle: the pre-shifted multiplicand times the lowest unretired multiplier slice
    always_comb begin
        partial   = mcand_q * DATA_W'(mplier_q[MUL_BITS_PER_CY-1:0]);
        acc_next  = acc_q + partial;
        last_step = (cnt_q == CNT_W'(N - 1));
    end

    // Completion is reported on the final accumulate edge so the top can register acc_next directly
    assign done_o    = busy_o & last_step & ~flush_i;
    assign product_o = acc_next;

    // Multiplier FSM: latch operands on start, retire one slice per edge, abort on flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            busy_o   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mcand_q  <= mcand_i;
                        mplier_q <= mplier_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL_RUN;
                        busy_o   <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        acc_q    <= acc_next;
                        mcand_q  <= mcand_q << MUL_BITS_PER_CY;
                        mplier_q <= mplier_q >> MUL_BITS_PER_CY;
                        cnt_q    <= cnt_q + 1'b1;
                        if (last_step) begin
                            state_q <= IDLE;
                            busy_o  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - EX-stage execute unit; ALU_EXEC_FAST_MUL_EN selects a single-cycle multiplier
import alu_exec_pkg::*;

module alu_exec #(
    parameter int DATA_W          = 32,
    parameter int MUL_BITS_PER_CY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic [ALU_CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0]     src1_i,
    input  logic [DATA_W-1:0]     src2_i,
    output logic [DATA_W-1:0]     result_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    alu_op_e           op;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0] alu_res;
    logic              accept;
    logic              is_mul;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign op     = alu_op_e'(ctrl_i);
    assign shamt  = src2_i[SHAMT_W-1:0];
    assign is_mul = (op == ALU_MUL);
    assign accept = valid_i & ~busy_o & ~flush_i;

    // Single-cycle datapath; reserved code yields zero but still completes
    always_comb begin
        alu_res = '0;
        case (op)
            ALU_AND:  alu_res = src1_i & src2_i;
            ALU_XOR:  alu_res = src1_i ^ src2_i;
            ALU_SLL:  alu_res = src1_i << shamt;
            ALU_ADD:  alu_res = src1_i + src2_i;
            ALU_SUB:  alu_res = src1_i - src2_i;
            ALU_SRAI: alu_res = $signed(src1_i) >>> shamt;
`ifdef ALU_EXEC_FAST_MUL_EN
            ALU_MUL:  alu_res = src1_i * src2_i;
`endif
            default:  alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_FAST_MUL_EN
    assign busy_o      = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;

    // Every op, MUL included, completes one cycle after acceptance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= accept & ~is_mul ? 1'b1 : accept;
            if (accept) begin
                result_o <= alu_res;
            end
        end
    end
`else
    alu_mul_iter #(
        .DATA_W          (DATA_W),
        .MUL_BITS_PER_CY (MUL_BITS_PER_CY)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (accept & is_mul),
        .flush_i   (flush_i),
        .mcand_i   (src1_i),
        .mplier_i  (src2_i),
        .busy_o    (busy_o),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Result register: multiplier completion or an accepted single-cycle op; otherwise hold
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (mul_done) begin
                result_o <= mul_product;
                valid_o  <= 1'b1;
            end else if (accept && !is_mul) begin
                result_o <= alu_res;
                valid_o  <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed table-driven bench for alu_exec
module tb_alu_exec;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        flush_i;
    logic [2:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [31:0] result_o;
    logic        valid_o;
    logic        busy_o;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef ALU_EXEC_FAST_MUL_EN
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_BUSY = 16;
`endif

    alu_exec dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .flush_i  (flush_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .result_o (result_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    logic        mon_en = 1'b0;
    logic [31:0] pulses[$];

    always @(posedge clk_i) begin
        #1;
        if (mon_en && valid_o) pulses.push_back(result_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_op(input string name, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk_i);
        ctrl_i = c; src1_i = a; src2_i = b; valid_i = 1'b1;
        @(posedge clk_i); #1;
        check({name, " valid"}, {31'b0, valid_o}, 32'd1);
        check({name, " result"}, result_o, exp);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        check({name, " pulse end"}, {31'b0, valid_o}, 32'd0);
        check({name, " hold"}, result_o, exp);
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int n;
        @(negedge clk_i);
        ctrl_i = 3'b101; src1_i = a; src2_i = b; valid_i = 1'b1;
        @(posedge clk_i); #1;
        n = 0;
        while (busy_o && n < 40) begin
            if (valid_o) check({name, " early valid"}, {31'b0, valid_o}, 32'd0);
            if (n == 0) valid_i = 1'b1;
            @(posedge clk_i); #1;
            n++;
        end
        check({name, " busy cycles"}, n, MUL_BUSY);
        check({name, " valid"}, {31'b0, valid_o}, 32'd1);
        check({name, " result"}, result_o, exp);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        check({name, " pulse end"}, {31'b0, valid_o}, 32'd0);
    endtask

    initial begin
        int n;
        int vcount;

        vecs[0]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[1]  = '{3'b100, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[2]  = '{3'b001, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0};
        vecs[3]  = '{3'b010, 32'h0000_0001, 32'd31,        32'h8000_0000};
        vecs[4]  = '{3'b110, 32'h8000_0000, 32'd4,         32'hF800_0000};
        vecs[5]  = '{3'b010, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
        vecs[6]  = '{3'b110, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000};
        vecs[7]  = '{3'b110, 32'h7FFF_FFF0, 32'd4,         32'h07FF_FFFF};
        vecs[8]  = '{3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00};
        vecs[9]  = '{3'b111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
        vecs[10] = '{3'b011, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789};
        vecs[11] = '{3'b100, 32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFF0};

        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        ctrl_i = 3'b000; src1_i = '0; src2_i = '0;
        repeat (2) @(negedge clk_i);
        check("reset result", result_o, 32'd0);
        check("reset valid", {31'b0, valid_o}, 32'd0);
        check("reset busy", {31'b0, busy_o}, 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp);

        run_mul("mul small", 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38);
        run_mul("mul ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

        // flush in idle drops the incoming op and leaves result_o alone
        @(negedge clk_i);
        ctrl_i = 3'b011; src1_i = 32'd100; src2_i = 32'd1; valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        check("idle flush valid", {31'b0, valid_o}, 32'd0);
        check("idle flush hold", result_o, 32'h0000_0001);
        @(negedge clk_i);
        valid_i = 1'b0; flush_i = 1'b0;

`ifndef ALU_EXEC_FAST_MUL_EN
        // flush five cycles into a MUL aborts without a result pulse
        @(negedge clk_i);
        ctrl_i = 3'b101; src1_i = 32'h0000_0007; src2_i = 32'h0000_0003; valid_i = 1'b1;
        @(posedge clk_i);
        repeat (5) @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        check("mul flush busy", {31'b0, busy_o}, 32'd0);
        check("mul flush valid", {31'b0, valid_o}, 32'd0);
        @(negedge clk_i);
        flush_i = 1'b0; valid_i = 1'b0;
        vcount = 0;
        repeat (20) begin
            @(posedge clk_i); #1;
            if (valid_o) vcount++;
        end
        check("mul flush no pulse", vcount, 0);
        run_op("add after flush", 3'b011, 32'd2, 32'd3, 32'd5);

        // asynchronous reset in the middle of a MUL
        @(negedge clk_i);
        ctrl_i = 3'b101; src1_i = 32'h0000_00FF; src2_i = 32'h0000_00FF; valid_i = 1'b1;
        @(posedge clk_i);
        repeat (3) @(negedge clk_i);
        valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check("async rst result", result_o, 32'd0);
        check("async rst valid", {31'b0, valid_o}, 32'd0);
        check("async rst busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        vcount = 0;
        repeat (20) begin
            @(posedge clk_i); #1;
            if (valid_o) vcount++;
        end
        check("post rst no pulse", vcount, 0);
`endif

        // back-to-back ADD, MUL, AND with valid_i held through busy
        pulses.delete();
        mon_en = 1'b1;
        @(negedge clk_i);
        ctrl_i = 3'b011; src1_i = 32'd7; src2_i = 32'd8; valid_i = 1'b1;
        @(negedge clk_i);
        ctrl_i = 3'b101; src1_i = 32'd3; src2_i = 32'd5;
        @(posedge clk_i); #1;
        n = 0;
        while (busy_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        @(negedge clk_i);
        ctrl_i = 3'b000; src1_i = 32'h0000_000C; src2_i = 32'h0000_000A;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        mon_en = 1'b0;
        check("b2b pulse count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("b2b add", pulses[0], 32'd15);
            check("b2b mul", pulses[1], 32'd15);
            check("b2b and", pulses[2], 32'h0000_0008);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
